// File: rtl/data_sram_like_slave.sv
// SRAM-like data slave: word memory with byte strobes and an in-order response FIFO
// that answers every accepted request exactly LAT cycles after its handshake.
module data_sram_like_slave #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2,
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(QDEPTH);
    localparam logic [2:0]       CD_INIT  = 3'(LAT);

    logic [31:0]      mem_r [0:(2**ADDR_W)-1];
    logic             q_wr_r   [0:QDEPTH-1];
    logic [31:0]      q_data_r [0:QDEPTH-1];
    logic [2:0]       q_cd_r   [0:QDEPTH-1];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_inc_s;
    logic [PTR_W-1:0] rd_ptr_inc_s;
    logic [CNT_W-1:0] outst_r;
    logic [31:0]      rdata_hold_r;
    logic [31:0]      rdata_s;
    logic             pop_s;
    logic             addr_ok_s;
    logic             hs_s;
    logic [ADDR_W-1:0] idx_s;
    logic             unused_bits_s;

    // Upper and sub-word address bits alias; size is informational only
    assign idx_s         = data_sram_addr[ADDR_W+1:2];
    assign unused_bits_s = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Response due at the FIFO head, acceptance decode and pointer wrap
    always_comb begin
        pop_s        = 1'b0;
        addr_ok_s    = 1'b0;
        hs_s         = 1'b0;
        rdata_s      = rdata_hold_r;
        wr_ptr_inc_s = wr_ptr_r;
        rd_ptr_inc_s = rd_ptr_r;
        if ((outst_r != CNT_W'(0)) && (q_cd_r[rd_ptr_r] == 3'd1)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        addr_ok_s = (outst_r < CNT_MAX) || pop_s;
        hs_s      = data_sram_req && addr_ok_s;
        if (pop_s) begin
            if (q_wr_r[rd_ptr_r]) begin
                rdata_s = 32'h0;
            end else begin
                rdata_s = q_data_r[rd_ptr_r];
            end
        end else begin
            rdata_s = rdata_hold_r;
        end
        if (wr_ptr_r == PTR_LAST) begin
            wr_ptr_inc_s = PTR_W'(0);
        end else begin
            wr_ptr_inc_s = wr_ptr_r + PTR_W'(1);
        end
        if (rd_ptr_r == PTR_LAST) begin
            rd_ptr_inc_s = PTR_W'(0);
        end else begin
            rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);
        end
    end

    assign data_sram_addr_ok = addr_ok_s;
    assign data_sram_data_ok = pop_s;
    assign data_sram_rdata   = rdata_s;

    // Response FIFO, outstanding count and held read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r     <= PTR_W'(0);
            rd_ptr_r     <= PTR_W'(0);
            outst_r      <= CNT_W'(0);
            rdata_hold_r <= 32'h0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_wr_r[i]   <= 1'b0;
                q_data_r[i] <= 32'h0;
                q_cd_r[i]   <= 3'd0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (q_cd_r[i] != 3'd0) begin
                    q_cd_r[i] <= q_cd_r[i] - 3'd1;
                end
            end
            // A push into the slot being popped on a full FIFO overrides the decrement
            if (hs_s) begin
                q_wr_r[wr_ptr_r]   <= data_sram_wr;
                q_data_r[wr_ptr_r] <= mem_r[idx_s];
                q_cd_r[wr_ptr_r]   <= CD_INIT;
                wr_ptr_r           <= wr_ptr_inc_s;
            end
            if (pop_s) begin
                rd_ptr_r     <= rd_ptr_inc_s;
                rdata_hold_r <= rdata_s;
            end
            case ({hs_s, pop_s})
                2'b10:   outst_r <= outst_r + CNT_W'(1);
                2'b01:   outst_r <= outst_r - CNT_W'(1);
                default: outst_r <= outst_r;
            endcase
        end
    end

    // Byte-lane memory update; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (hs_s && data_sram_wr && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    mem_r[idx_s][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_sram_like_slave.md
DATA_SRAM_LIKE_SLAVE -- requirements
Module: data_sram_like_slave

Interface
REQ-001 Parameter ADDR_W, default 10, word-index width; memory holds 2**ADDR_W 32-bit words.
REQ-002 Parameter LAT, default 2, legal 1..4, request-accept-to-data_ok latency in cycles.
REQ-003 Parameter QDEPTH, default 2, maximum outstanding (accepted, not yet responded) requests.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_sram_req  input  1  request valid.
REQ-007 data_sram_wr  input  1  1 = write, 0 = read.
REQ-008 data_sram_size  input  2  access size (0 = byte, 1 = half, 2 = word); informational only.
REQ-009 data_sram_addr  input  32  byte address; word index = addr[ADDR_W+1:2], all other bits ignored (aliasing).
REQ-010 data_sram_wstrb  input  4  byte-lane write enables, bit i = bits 8i+7:8i.
REQ-011 data_sram_wdata  input  32  write data.
REQ-012 data_sram_addr_ok  output  1  request accepted this cycle when high together with data_sram_req.
REQ-013 data_sram_data_ok  output  1  one-cycle response pulse, one per accepted request.
REQ-014 data_sram_rdata  output  32  read data, valid while data_ok is high.

Function
REQ-015 Handshake: data_sram_req && data_sram_addr_ok; at most one request is accepted per cycle.
REQ-016 data_sram_addr_ok = (outstanding < QDEPTH) || data_sram_data_ok, combinational; it does not depend on data_sram_req.
REQ-017 Outstanding count: +1 on handshake, -1 on the data_ok cycle; a handshake and data_ok in the same cycle leave the count unchanged.
REQ-018 The count never exceeds QDEPTH and never underflows.
REQ-019 Accepted write: at the handshake edge, memory bytes with wstrb=1 are updated and bytes with wstrb=0 are kept; wstrb=0000 is a legal no-op write that still responds.
REQ-020 Accepted read: data is sampled from memory at the handshake edge.
REQ-021 A read observes every write accepted in an earlier cycle, including a write accepted in the immediately preceding cycle.
REQ-022 Each accepted request enters a QDEPTH-entry FIFO holding {wr, rdata snapshot, countdown = LAT}.
REQ-023 Countdowns decrement every cycle; data_sram_data_ok is asserted in exactly cycle T+LAT for a request accepted in cycle T.
REQ-024 Responses are returned strictly in acceptance order; data_ok is never asserted twice in one cycle.
REQ-025 FIFO read/write pointers wrap modulo QDEPTH; a same-cycle push and pop on a full FIFO are both legal.
REQ-026 On a read response, data_sram_rdata = the sampled word.
REQ-027 On a write response, data_sram_rdata = 32'h0.
REQ-028 When data_ok is low, data_sram_rdata holds its last driven value.
REQ-029 With LAT <= QDEPTH, back-to-back requests every cycle are accepted without stall.
REQ-030 With LAT > QDEPTH, addr_ok drops whenever the FIFO is full and no response is due in that cycle.
REQ-031 The block ignores all inputs other than reset on cycles without a handshake.
REQ-032 The block provides no cancel or flush input; every accepted request is always answered.

Reset
REQ-033 While reset is high: outstanding = 0, FIFO empty, FIFO pointers = 0, data_ok = 0, rdata = 32'h0, addr_ok = 1.
REQ-034 Memory contents are not reset; they are preserved across reset.
REQ-035 Reset asserted mid-operation discards all in-flight responses; no data_ok follows deassertion until a new handshake.
REQ-036 A write that completed its handshake edge before reset asserts remains in memory.

Verification
REQ-037 Write 0x12345678 to 0x100 with wstrb 1111, then read 0x100 -> write data_ok at T+2 with rdata 0; read data_ok at T'+2 with rdata 0x12345678.
REQ-038 Preload 0x100 = 0x12345678, write 0xAABBCCDD with wstrb 0101, read 0x100 in the next cycle -> read returns 0x12BB56DD.
REQ-039 LAT=2, QDEPTH=2, reads of 0x0/0x4/0x8/0xC held on consecutive cycles -> addr_ok stays 1; data_ok high for 4 consecutive cycles; rdata in address order.
REQ-040 LAT=4, QDEPTH=2, req held high continuously -> addr_ok low in cycles 2-3; the first data_ok occurs in cycle 4, the same cycle addr_ok rises; outstanding never exceeds 2.
REQ-041 Assert reset one cycle after accepting a read -> data_ok stays 0 after deassertion; addr_ok = 1; memory contents unchanged.
REQ-042 Address 0x1000 with ADDR_W=10 -> aliases to word 0; writing 0x1000 then reading 0x0 returns the written value.
